// File: rtl/imi_snapshot.sv
// Burst capture of imitator {q,i} samples into block RAM, triggered on the first
// fix_pulse after arming, with optional decimation and a registered CPU read port.
module imi_snapshot #(
  parameter int WIDTH = 16,
  parameter int AW    = 10,
  parameter int DW    = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               fix_pulse,
  input  logic               arm,
  input  logic               abort,
  input  logic [AW-1:0]      depth,
  input  logic [DW-1:0]      decim,
  input  logic [WIDTH-1:0]   imi_i,
  input  logic [WIDTH-1:0]   imi_q,
  input  logic               imi_valid,
  input  logic               rd_en,
  input  logic [AW-1:0]      rd_addr,
  output logic [2*WIDTH-1:0] rd_data,
  output logic               rd_valid,
  output logic               busy,
  output logic               done,
  output logic [AW:0]        wr_count
);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_CAPTURE, S_DONE} state_t;

  state_t             state;
  logic [AW-1:0]      depth_q;
  logic [DW-1:0]      decim_q;
  logic [DW-1:0]      dec_cnt;
  logic [AW-1:0]      wr_ptr;
  logic [2*WIDTH-1:0] mem [0:2**AW-1];

  logic we;
  logic last_word;

  // A write is suppressed on abort/rst cycles so the FSM and RAM never disagree.
  assign we        = (state == S_CAPTURE) && imi_valid && (dec_cnt == '0) && !abort && !rst;
  assign last_word = ({1'b0, depth_q} == wr_count);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      wr_count <= '0;
      wr_ptr   <= '0;
      dec_cnt  <= '0;
      depth_q  <= '0;
      decim_q  <= '0;
    end else if (abort) begin
      state <= S_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (arm) begin
            state    <= S_ARMED;
            busy     <= 1'b1;
            done     <= 1'b0;
            depth_q  <= depth;
            decim_q  <= decim;
            wr_count <= '0;
            wr_ptr   <= '0;
            dec_cnt  <= '0;
          end
        end
        S_ARMED: begin
          if (fix_pulse) state <= S_CAPTURE;
        end
        S_CAPTURE: begin
          if (imi_valid) begin
            if (dec_cnt == '0) begin
              wr_ptr   <= wr_ptr + 1'b1;
              wr_count <= wr_count + 1'b1;
              dec_cnt  <= decim_q;
              if (last_word) begin
                state <= S_DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end
            end else begin
              dec_cnt <= dec_cnt - 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // NOTE: the RAM array is deliberately not reset; a reset would prevent
  // block-RAM inference and the contents are meaningless until written.
  always_ff @(posedge clk) begin
    if (we) mem[wr_ptr] <= {imi_q, imi_i};
  end

  // Read-first: a same-edge read of the address being written returns the old word.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: tb/tb_imi_snapshot.sv
// Directed bench for imi_snapshot: status checks inline, read data checked by a
// scoreboard queue popped by an independent monitor whenever rd_valid is due.
module tb_imi_snapshot;
  localparam int WIDTH = 16;
  localparam int AW    = 10;
  localparam int DW    = 8;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               fix_pulse = 1'b0;
  logic               arm = 1'b0;
  logic               abort = 1'b0;
  logic [AW-1:0]      depth = '0;
  logic [DW-1:0]      decim = '0;
  logic [WIDTH-1:0]   imi_i = '0;
  logic [WIDTH-1:0]   imi_q = '1;
  logic               imi_valid = 1'b1;
  logic               rd_en = 1'b0;
  logic [AW-1:0]      rd_addr = '0;
  logic [2*WIDTH-1:0] rd_data;
  logic               rd_valid;
  logic               busy;
  logic               done;
  logic [AW:0]        wr_count;

  imi_snapshot #(.WIDTH(WIDTH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst), .fix_pulse(fix_pulse), .arm(arm), .abort(abort),
    .depth(depth), .decim(decim), .imi_i(imi_i), .imi_q(imi_q), .imi_valid(imi_valid),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .busy(busy), .done(done), .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  logic [2*WIDTH-1:0] sb [$];
  logic exp_rd = 1'b0;
  logic [15:0] cnt = '0;
  logic toggle = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [2*WIDTH-1:0] word_of(input logic [15:0] s);
    return {~s, s};
  endfunction

  // One clock: inputs set before the call are consumed at the posedge; a new sample follows.
  task automatic tick();
    @(posedge clk);
    #1;
    cnt       = cnt + 16'd1;
    imi_i     = cnt;
    imi_q     = ~cnt;
    imi_valid = toggle ? cnt[0] : 1'b1;
  endtask

  task automatic wait_done(input string name, input int exp_ticks);
    int n = 0;
    while (!done && n < 3000) begin
      tick();
      n++;
    end
    check(name, 64'(n), 64'(exp_ticks));
  endtask

  task automatic do_arm(input logic [AW-1:0] d, input logic [DW-1:0] m);
    depth = d;
    decim = m;
    arm   = 1'b1;
    tick();
    arm   = 1'b0;
  endtask

  // Pulses fix_pulse; returns the sample value present on the fix_pulse cycle.
  task automatic do_fix(output logic [15:0] c0);
    c0        = cnt;
    fix_pulse = 1'b1;
    tick();
    fix_pulse = 1'b0;
  endtask

  task automatic read_burst(input int base, input int n, input logic [15:0] first, input int stride);
    for (int k = 0; k < n; k++) begin
      rd_en   = 1'b1;
      rd_addr = AW'(base + k);
      sb.push_back(word_of(first + 16'(stride * k)));
      tick();
    end
    rd_en = 1'b0;
  endtask

  always @(posedge clk) exp_rd <= rst ? 1'b0 : rd_en;

  // Monitor: compares read responses against the scoreboard, independent of stimulus.
  always @(negedge clk) begin
    if (exp_rd || rd_valid) begin
      check("rd_valid", 64'(rd_valid), 64'(exp_rd));
      if (exp_rd && sb.size() > 0) check("rd_data", 64'(rd_data), 64'(sb.pop_front()));
    end
  end

  initial begin
    logic [15:0] c0, c_dec, c_tog, c_full, c5, c6, c_ab, c7, first;

    // Power-on reset
    repeat (3) tick();
    rst = 1'b0;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_wr_count", 64'(wr_count), 64'd0);
    check("rst_rd_valid", 64'(rd_valid), 64'd0);

    // Basic capture: 16 consecutive samples
    do_arm(10'd15, 8'd0);
    check("armed_busy", 64'(busy), 64'd1);
    do_fix(c0);
    wait_done("basic_latency", 16);
    check("basic_done", 64'(done), 64'd1);
    check("basic_busy", 64'(busy), 64'd0);
    check("basic_wr_count", 64'(wr_count), 64'd16);
    read_burst(0, 16, c0 + 16'd1, 1);

    // Decimation by 4, valid every cycle: words at sample offsets 1,5,...,29
    do_arm(10'd7, 8'd3);
    check("arm_in_done_wr_count", 64'(wr_count), 64'd0);
    check("arm_in_done_done", 64'(done), 64'd0);
    do_fix(c_dec);
    wait_done("decim_latency", 29);
    check("decim_wr_count", 64'(wr_count), 64'd8);
    read_burst(0, 8, c_dec + 16'd1, 4);

    // Decimation by 4 with valid on odd samples only: one word every 8 cycles
    toggle = 1'b1;
    do_arm(10'd7, 8'd3);
    do_fix(c_tog);
    first = c_tog[0] ? c_tog + 16'd2 : c_tog + 16'd1;
    wait_done("toggle_latency", int'(first - c_tog) + 56);
    check("toggle_wr_count", 64'(wr_count), 64'd8);
    toggle = 1'b0;
    imi_valid = 1'b1;
    read_burst(0, 8, first, 8);

    // Full depth: 1024 words, pointer does not wrap onto word 0
    do_arm(10'h3FF, 8'd0);
    depth = 10'd3;
    decim = 8'd5;
    do_fix(c_full);
    wait_done("full_latency", 1024);
    check("full_wr_count", 64'(wr_count), 64'd1024);
    check("full_busy", 64'(busy), 64'd0);
    read_burst(0, 2, c_full + 16'd1, 1);
    read_burst(1022, 2, c_full + 16'd1023, 1);

    // arm with abort in the same cycle -> IDLE
    arm = 1'b1;
    abort = 1'b1;
    tick();
    arm = 1'b0;
    abort = 1'b0;
    check("arm_abort_busy", 64'(busy), 64'd0);
    check("arm_abort_done", 64'(done), 64'd0);

    // fix_pulse while idle starts nothing
    do_fix(c0);
    tick();
    tick();
    check("fix_idle_busy", 64'(busy), 64'd0);
    check("fix_idle_done", 64'(done), 64'd0);

    // Second arm during capture is ignored
    do_arm(10'd15, 8'd0);
    check("arm_idle_wr_count", 64'(wr_count), 64'd0);
    do_fix(c5);
    repeat (5) tick();
    check("mid_wr_count", 64'(wr_count), 64'd5);
    depth = 10'd2;
    arm = 1'b1;
    tick();
    arm = 1'b0;
    check("rearm_busy", 64'(busy), 64'd1);
    check("rearm_wr_count", 64'(wr_count), 64'd6);
    wait_done("rearm_latency", 10);
    check("rearm_final_count", 64'(wr_count), 64'd16);
    read_burst(0, 16, c5 + 16'd1, 1);

    // Same-address read during write returns the old word
    do_arm(10'd15, 8'd0);
    do_fix(c6);
    repeat (3) tick();
    rd_en = 1'b1;
    rd_addr = 10'd3;
    sb.push_back(word_of(c5 + 16'd4));
    tick();
    rd_en = 1'b0;
    wait_done("rfw_latency", 12);
    read_burst(3, 1, c6 + 16'd4, 1);

    // Abort mid-capture
    do_arm(10'd15, 8'd0);
    do_fix(c_ab);
    repeat (3) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);

    // Reset mid-capture; partial RAM contents survive
    do_arm(10'd15, 8'd0);
    do_fix(c7);
    repeat (4) tick();
    rst = 1'b1;
    tick();
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    check("midrst_wr_count", 64'(wr_count), 64'd0);
    check("midrst_rd_valid", 64'(rd_valid), 64'd0);
    repeat (2) tick();
    rst = 1'b0;
    read_burst(1, 1, c7 + 16'd2, 1);
    read_burst(5, 1, c6 + 16'd6, 1);

    repeat (3) tick();
    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
